// File: rtl/ah_lru_arbiter_n_pkg.sv
// Shared types and helpers for the AH LRU arbiter: FSM state, width helper,
// one-hot decode and max-rank selection over fixed-maximum-width vectors.
package ah_arb_pkg;

  localparam int unsigned MAX_N   = 64;
  localparam int unsigned MAX_IDW = 6;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_IDW-1:0] onehot_to_index(input logic [MAX_N-1:0] oh);
    logic [MAX_IDW-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | MAX_IDW'(i);
    end
    return idx;
  endfunction

  // Ranks are packed at a fixed MAX_IDW stride; unused lanes must be masked off.
  function automatic logic [MAX_N-1:0] max_rank_select(input logic [MAX_N-1:0]         mask,
                                                       input logic [MAX_N*MAX_IDW-1:0] ranks);
    logic [MAX_N-1:0]   sel;
    logic [MAX_IDW-1:0] best;
    logic               found;
    sel   = '0;
    best  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (mask[i] && (!found || (ranks[i*MAX_IDW +: MAX_IDW] > best))) begin
        sel    = '0;
        sel[i] = 1'b1;
        best   = ranks[i*MAX_IDW +: MAX_IDW];
        found  = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/ah_lru_arbiter_n_if.sv
// Request/grant bundle between requesters and the AH LRU arbiter.
interface ah_lru_arbiter_n_if
  import ah_arb_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = clog2_min1(N)
);
  logic [N-1:0]     req;
  logic [N-1:0]     gnt_busy;
  logic [N-1:0]     req_last;
  logic [N-1:0]     gnt;
  logic             gnt_vld;
  logic [IDW-1:0]   gnt_id;
  logic [N*IDW-1:0] lru_rank;

  modport master (
    output req, gnt_busy, req_last,
    input  gnt, gnt_vld, gnt_id, lru_rank
  );

  modport slave (
    input  req, gnt_busy, req_last,
    output gnt, gnt_vld, gnt_id, lru_rank
  );
endinterface

// File: rtl/ah_lru_arbiter_n_rank_tracker.sv
// True-LRU rank permutation: picks the highest-ranked requester in a mask and
// moves it to rank 0 when a grant is issued.
module ah_lru_rank_tracker
  import ah_arb_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = clog2_min1(N)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [N-1:0]     i_mask,
  input  logic             i_upd,
  output logic [N-1:0]     o_win_oh,
  output logic [IDW-1:0]   o_win_idx,
  output logic [N*IDW-1:0] o_lru_rank
);
  logic [IDW-1:0]           r_rank [N];
  logic [MAX_N-1:0]         w_mask_ext;
  logic [MAX_N-1:0]         w_win_ext;
  logic [MAX_N*MAX_IDW-1:0] w_rank_ext;
  logic [MAX_IDW-1:0]       w_idx_ext;
  logic [IDW-1:0]           w_win_rank;
  logic                     w_unused;

  always_comb begin
    w_mask_ext          = '0;
    w_rank_ext          = '0;
    w_mask_ext[N-1:0]   = i_mask;
    for (int unsigned i = 0; i < N; i++) begin
      w_rank_ext[i*MAX_IDW +: MAX_IDW] = MAX_IDW'(r_rank[i]);
    end
  end

  assign w_win_ext = max_rank_select(w_mask_ext, w_rank_ext);
  assign w_idx_ext = onehot_to_index(w_win_ext);
  assign o_win_oh  = w_win_ext[N-1:0];
  assign o_win_idx = w_idx_ext[IDW-1:0];
  assign w_unused  = ^{w_win_ext, w_idx_ext};

  always_comb begin
    w_win_rank = '0;
    o_lru_rank = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (o_win_oh[i]) w_win_rank = r_rank[i];
      o_lru_rank[i*IDW +: IDW] = r_rank[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int unsigned i = 0; i < N; i++) r_rank[i] <= IDW'(N - 1 - i);
    end else if (i_upd) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (o_win_oh[i])                r_rank[i] <= '0;
        else if (r_rank[i] < w_win_rank) r_rank[i] <= r_rank[i] + IDW'(1);
      end
    end
  end

endmodule

// File: rtl/ah_lru_arbiter_n.sv
// N-way LRU arbiter with busy masking and optional grant hold until release;
// grant, valid and index are registered one cycle after an eligible request.
module ah_lru_arbiter_n
  import ah_arb_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned IDW       = clog2_min1(N),
  parameter bit          HOLD_MODE = 1'b1
) (
  input logic               clk,
  input logic               rstn,
  ah_lru_arbiter_n_if.slave bus
);
  arb_state_e     r_state, w_state_nxt;
  logic [N-1:0]   w_elig, w_win_oh, r_gnt, w_gnt_nxt;
  logic [IDW-1:0] w_win_idx, r_gnt_id, w_gnt_id_nxt;
  logic           r_gnt_vld, w_vld_nxt;
  logic           w_release, w_arb, w_upd;

  assign w_elig = bus.req & ~bus.gnt_busy;

  ah_lru_rank_tracker #(
    .N   (N),
    .IDW (IDW)
  ) u_rank (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_mask     (w_elig),
    .i_upd      (w_upd),
    .o_win_oh   (w_win_oh),
    .o_win_idx  (w_win_idx),
    .o_lru_rank (bus.lru_rank)
  );

  // Owner is the one-hot r_gnt, so release needs no index into req.
  assign w_release = |(r_gnt & (~bus.req | bus.req_last));
  assign w_arb     = !HOLD_MODE || (r_state == IDLE) || w_release;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!HOLD_MODE)  w_state_nxt = IDLE;
    else if (w_arb)  w_state_nxt = (|w_elig) ? OWNED : IDLE;
  end

  always_comb begin
    w_upd        = 1'b0;
    w_gnt_nxt    = r_gnt;
    w_gnt_id_nxt = r_gnt_id;
    w_vld_nxt    = r_gnt_vld;
    if (w_arb) begin
      if (|w_elig) begin
        w_upd        = 1'b1;
        w_gnt_nxt    = w_win_oh;
        w_gnt_id_nxt = w_win_idx;
        w_vld_nxt    = 1'b1;
      end else begin
        w_gnt_nxt    = '0;
        w_gnt_id_nxt = '0;
        w_vld_nxt    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_gnt_vld <= 1'b0;
    end else begin
      r_gnt     <= w_gnt_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_gnt_vld <= w_vld_nxt;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_id  = r_gnt_id;
  assign bus.gnt_vld = r_gnt_vld;

endmodule

// File: tb/tb_ah_lru_arbiter_n.sv
// Directed vector bench for ah_lru_arbiter_n: one instance per HOLD_MODE,
// expected grants and LRU ranks computed by hand.
module tb_ah_lru_arbiter_n;

  typedef struct {
    bit         rst;
    bit         hold;
    logic [3:0] req;
    logic [3:0] busy;
    logic [3:0] last;
    logic [3:0] gnt;
    bit         chk_rank;
    logic [7:0] rank;
  } vec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  ah_lru_arbiter_n_if #(.N(4), .IDW(2)) if0 ();
  ah_lru_arbiter_n_if #(.N(4), .IDW(2)) if1 ();

  ah_lru_arbiter_n #(.N(4), .IDW(2), .HOLD_MODE(1'b0)) u_dut0 (.clk(clk), .rstn(rstn), .bus(if0));
  ah_lru_arbiter_n #(.N(4), .IDW(2), .HOLD_MODE(1'b1)) u_dut1 (.clk(clk), .rstn(rstn), .bus(if1));

  function automatic vec_t mk(input bit rst, input bit hold, input logic [3:0] req,
                              input logic [3:0] busy, input logic [3:0] last,
                              input logic [3:0] gnt, input bit cr, input logic [7:0] rank);
    vec_t v;
    v.rst = rst; v.hold = hold; v.req = req; v.busy = busy; v.last = last;
    v.gnt = gnt; v.chk_rank = cr; v.rank = rank;
    return v;
  endfunction

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) if (oh[i]) idx = 2'(i);
    return idx;
  endfunction

  function automatic logic is_perm(input logic [7:0] rk);
    logic [3:0] seen;
    logic [1:0] f;
    seen = '0;
    for (int i = 0; i < 4; i++) begin
      f = rk[i*2 +: 2];
      seen[f] = 1'b1;
    end
    return (seen == 4'b1111);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit hold, input logic [3:0] req, input logic [3:0] busy,
                       input logic [3:0] last);
    if0.req = '0; if0.gnt_busy = '0; if0.req_last = '0;
    if1.req = '0; if1.gnt_busy = '0; if1.req_last = '0;
    if (hold) begin
      if1.req = req; if1.gnt_busy = busy; if1.req_last = last;
    end else begin
      if0.req = req; if0.gnt_busy = busy; if0.req_last = last;
    end
  endtask

  task automatic sample(input bit hold, output logic [3:0] g, output logic v,
                        output logic [1:0] id, output logic [7:0] rk);
    if (hold) begin
      g = if1.gnt; v = if1.gnt_vld; id = if1.gnt_id; rk = if1.lru_rank;
    end else begin
      g = if0.gnt; v = if0.gnt_vld; id = if0.gnt_id; rk = if0.lru_rank;
    end
  endtask

  task automatic check_reset_state(input string tag);
    logic [3:0] g;
    logic       v;
    logic [1:0] id;
    logic [7:0] rk;
    for (int h = 0; h < 2; h++) begin
      sample(h[0], g, v, id, rk);
      check($sformatf("%s.h%0d.gnt", tag, h), 32'(g), 32'h0);
      check($sformatf("%s.h%0d.vld", tag, h), 32'(v), 32'h0);
      check($sformatf("%s.h%0d.id", tag, h), 32'(id), 32'h0);
      check($sformatf("%s.h%0d.rank", tag, h), 32'(rk), 32'h1B);
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 4'b0, 4'b0, 4'b0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_reset_state("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g;
    logic       v;
    logic [1:0] id;
    logic [7:0] rk;

    // HOLD_MODE=0: full request, LRU rotation
    vecs.push_back(mk(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 8'h1B));
    vecs.push_back(mk(0, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1, 8'h6C));
    vecs.push_back(mk(0, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 1, 8'hB1));
    vecs.push_back(mk(0, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1, 8'hC6));
    vecs.push_back(mk(0, 0, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 1, 8'h1B));
    vecs.push_back(mk(0, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1, 8'h6C));
    // HOLD_MODE=0: LRU rather than round-robin
    vecs.push_back(mk(1, 0, 4'b0101, 4'b0000, 4'b0000, 4'b0001, 0, 8'h00));
    vecs.push_back(mk(0, 0, 4'b0101, 4'b0000, 4'b0000, 4'b0100, 0, 8'h00));
    vecs.push_back(mk(0, 0, 4'b0101, 4'b0000, 4'b0000, 4'b0001, 0, 8'h00));
    vecs.push_back(mk(0, 0, 4'b0101, 4'b0000, 4'b0000, 4'b0100, 1, 8'h8D));
    vecs.push_back(mk(0, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 0, 8'h00));
    vecs.push_back(mk(0, 0, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 1, 8'h27));
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 8'h27));
    // HOLD_MODE=0: busy masking keeps requester 0 at rank 3
    vecs.push_back(mk(1, 0, 4'b1111, 4'b0001, 4'b0000, 4'b0010, 0, 8'h00));
    vecs.push_back(mk(0, 0, 4'b1111, 4'b0001, 4'b0000, 4'b0100, 1, 8'h87));
    vecs.push_back(mk(0, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 0, 8'h00));
    // HOLD_MODE=1: hold, busy mid-hold, release on last, no bubble
    vecs.push_back(mk(1, 1, 4'b0110, 4'b0000, 4'b0000, 4'b0010, 1, 8'h63));
    vecs.push_back(mk(0, 1, 4'b0110, 4'b0010, 4'b0000, 4'b0010, 0, 8'h00));
    vecs.push_back(mk(0, 1, 4'b0110, 4'b0000, 4'b0000, 4'b0010, 1, 8'h63));
    vecs.push_back(mk(0, 1, 4'b0110, 4'b0000, 4'b0010, 4'b0100, 1, 8'h87));
    vecs.push_back(mk(0, 1, 4'b0110, 4'b0000, 4'b0000, 4'b0100, 0, 8'h00));
    // owner 2 drops req without last, then release with nothing eligible
    vecs.push_back(mk(0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 8'hD8));
    vecs.push_back(mk(0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 8'h00));
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 8'h00));
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 8'hD8));
    // sole eligible owner re-wins at release; otherwise the LRU peer does
    vecs.push_back(mk(0, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 0, 8'h00));
    vecs.push_back(mk(0, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 1, 8'hD8));
    vecs.push_back(mk(0, 1, 4'b0011, 4'b0000, 4'b0001, 4'b0010, 1, 8'hE1));

    drive(1'b0, 4'b0, 4'b0, 4'b0);
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      drive(vecs[i].hold, vecs[i].req, vecs[i].busy, vecs[i].last);
      @(posedge clk);
      #1;
      sample(vecs[i].hold, g, v, id, rk);
      check($sformatf("v%0d.gnt", i), 32'(g), 32'(vecs[i].gnt));
      check($sformatf("v%0d.vld", i), 32'(v), 32'(|vecs[i].gnt));
      check($sformatf("v%0d.id", i), 32'(id), 32'(oh2idx(vecs[i].gnt)));
      check($sformatf("v%0d.perm", i), 32'(is_perm(rk)), 32'h1);
      if (vecs[i].chk_rank) check($sformatf("v%0d.rank", i), 32'(rk), 32'(vecs[i].rank));
    end

    // Asynchronous reset while HOLD_MODE=1 instance owns a grant
    do_reset();
    drive(1'b1, 4'b1111, 4'b0000, 4'b0000);
    @(posedge clk);
    #1;
    sample(1'b1, g, v, id, rk);
    check("async.pre.gnt", 32'(g), 32'h1);
    #3;
    rstn = 1'b0;
    #1;
    check_reset_state("async");
    @(negedge clk);
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    sample(1'b1, g, v, id, rk);
    check("async.post.gnt", 32'(g), 32'h1);
    check("async.post.rank", 32'(rk), 32'h6C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ah_lru_arbiter_n.md
Name: ah_lru_arbiter_n

Overview:
Parametrised N-way least-recently-used arbiter with per-requester busy masking and an optional grant-hold (packet lock) mode. Sits in front of shared targets (bus port, memory bank, crossbar output) in the AH fabric. It keeps a true LRU ordering as a rank permutation and registers the grant. The grant arrives one cycle after an eligible request.

Parameters:
N, 4, number of requesters (N >= 1)
IDW, $clog2(N) (min 1), width of grant index and of each rank field
HOLD_MODE, 1, 1: grant held until release; 0: single-cycle grants, re-arbitrated every cycle

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
req  input  N  request per requester
gnt_busy  input  N  per-requester busy; a busy requester is not eligible for a new grant
req_last  input  N  last beat of owner's transfer (HOLD_MODE=1 only, ignored otherwise)
gnt  output  N  registered one-hot grant
gnt_vld  output  1  high when gnt is nonzero
gnt_id  output  IDW  binary index of granted requester; 0 when gnt_vld=0
lru_rank  output  N*IDW  debug: rank of requester i at bits [i*IDW +: IDW]

Behaviour:
- Reset is asynchronous, active-low, clock clk. On reset: gnt=0, gnt_vld=0, gnt_id=0, state=IDLE, rank[i]=N-1-i. Requester 0 starts as the oldest.
- Rank N-1 is least recently used (highest priority). Rank 0 is most recently used. The ranks always form a permutation of 0..N-1.
- Eligibility: e = req & ~gnt_busy.
- Selection: the winner is the eligible requester with the maximum rank. Ranks are unique, so there are no ties.
- Rank update happens only at the edge that registers a new grant for winner w. rank[w] becomes 0. Every j with rank[j] < old rank[w] increments by 1. All other ranks are unchanged.
- Skipped, non-requesting and busy requesters keep their rank.
- Latency: eligible request at edge k produces gnt at edge k+1. Combinational path is from req/gnt_busy to next-state only; outputs are flops.
- HOLD_MODE=0:
  - Every cycle is an arbitration cycle; gnt lasts one cycle.
  - If e=0, gnt=0 on the next cycle.
- HOLD_MODE=1 state machine:
  - IDLE: if e != 0, register the winner's grant and go to OWNED. Otherwise stay in IDLE with gnt=0.
  - OWNED (owner o): gnt stays one-hot on o. gnt_busy[o] does not revoke the grant.
  - Release condition: req[o]=0, or req[o]&req_last[o] in the current cycle.
  - On release, the same edge re-arbitrates over e with ranks already updated (o is rank 0), so there is no bubble cycle.
  - o can win again only if it is the sole eligible requester. If e=0 at release, go to IDLE with gnt=0.
  - The rank update for a grant occurs once, at grant issue, not per held cycle.
- N=1: the requester is granted whenever eligible; rank stays 0.
- Asynchronous reset mid-ownership clears gnt/gnt_vld immediately and restores the reset ranks. Arbitration resumes on the first edge after rstn deasserts.
- A request withdrawn before being granted has no side effect.

Decomposition:
- Shared package ah_arb_pkg holds:
  - state enum {IDLE, OWNED};
  - onehot-to-index and max-rank-select functions;
  - a clog2-with-minimum-1 constant helper.
- One natural sub-module, ah_lru_rank_tracker:
  - contains the rank registers, the max-rank winner select over a mask, and the update-on-grant logic;
  - exposes winner one-hot/index and lru_rank.
- The top level holds eligibility, the HOLD_MODE FSM and the output registers.

Test Plan:
- N=4, HOLD_MODE=0, reset then req=4'b1111, busy=0: gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles; first gnt one cycle after req rises.
- HOLD_MODE=0, req=4'b0101 for 4 cycles gives gnt 0001,0100,0001,0100. Then req=4'b1111 gives 0010 then 1000, showing LRU rather than round-robin order. Check lru_rank stays a permutation.
- HOLD_MODE=0, req=4'b1111, gnt_busy=4'b0001 for 2 cycles gives gnt 0010,0100 with rank[0] still 3. Clear busy: the next gnt is 0001.
- HOLD_MODE=1, req=4'b0110 from reset: gnt=0010 held. Assert req_last[1] on the 3rd held cycle: gnt=0010 for exactly 3 cycles, then 0100 on the very next cycle. gnt_busy[1] pulsed mid-hold does not drop the grant.
- HOLD_MODE=1, owner 2 drops req without last while req[0]=1: gnt moves to 0001 the next cycle. With req all zero at release, gnt=0 and gnt_vld=0.
- Assert rstn=0 asynchronously mid-OWNED: gnt=0, gnt_vld=0, gnt_id=0 without a clock edge; lru_rank = {0,1,2,3} (fields for requesters 3..0). After release, req=4'b1111 grants 0001 first.
